// File: rtl/stack_cpu_core.sv
// Stack CPU core: FETCH/EXEC/HALT/FAULT sequencer around an internal data stack, one instruction per two cycles.
// Optional macro STK_CPU_FAULT_EN traps depth violations in FAULT; undefined, violations execute as NOPs.
module stack_cpu_core #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  output logic                    o_fetch_req,
  output logic [WIDTH-1:0]        o_instr_addr,
  input  logic                    i_fetch_ack,
  input  logic [WIDTH+1:0]        i_instr,
  output logic [WIDTH-1:0]        o_top,
  output logic [$clog2(DEPTH):0]  o_depth,
  output logic                    o_carry,
  output logic                    o_halted,
  output logic                    o_fault
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned DW = AW + 1;

  localparam logic [1:0] T_PUSH = 2'b00;
  localparam logic [1:0] T_ALU  = 2'b01;
  localparam logic [1:0] T_JUMP = 2'b10;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT, S_FAULT} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_top;
  logic [WIDTH+1:0] r_ir;
  logic [DW-1:0]    r_depth;
  logic             r_carry;
  logic             r_fetch_req;
  logic             r_halted;
  logic [WIDTH-1:0] r_stack [DEPTH];

  logic [1:0]       w_type;
  logic [WIDTH-1:0] w_pay;
  logic [AW-1:0]    w_idx_top;
  logic [AW-1:0]    w_idx_sec;
  logic [AW-1:0]    w_idx_new;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_empty;
  logic             w_full;
  logic             w_two;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_res_c;
  logic             w_viol;
  logic             w_wr_en;
  logic [AW-1:0]    w_wr_idx;
  logic [WIDTH-1:0] w_wr_data;
  logic [DW-1:0]    w_depth_nx;
  logic             w_carry_nx;
  logic [WIDTH-1:0] w_top_nx;
  logic             w_taken;
  logic [WIDTH-1:0] w_target;

  assign w_type    = r_ir[WIDTH+1:WIDTH];
  assign w_pay     = r_ir[WIDTH-1:0];
  assign w_idx_top = AW'(r_depth - DW'(1));
  assign w_idx_sec = AW'(r_depth - DW'(2));
  assign w_idx_new = AW'(r_depth);
  assign w_b       = r_stack[w_idx_top];
  assign w_a       = r_stack[w_idx_sec];
  assign w_empty   = (r_depth == '0);
  assign w_full    = (r_depth == DW'(DEPTH));
  assign w_two     = (r_depth >= DW'(2));
  assign w_target  = {2'b00, w_pay[WIDTH-3:0]};

  // Binary ALU result and carry for a op b (a = second, b = top)
  always_comb begin
    w_sum   = '0;
    w_res   = '0;
    w_res_c = r_carry;
    case (w_pay[2:0])
      3'd0: begin
        w_sum   = {1'b0, w_a} + {1'b0, w_b};
        w_res   = w_sum[WIDTH-1:0];
        w_res_c = w_sum[WIDTH];
      end
      3'd1: begin
        w_sum   = {1'b0, w_a} + {1'b0, w_b} + (WIDTH+1)'(r_carry);
        w_res   = w_sum[WIDTH-1:0];
        w_res_c = w_sum[WIDTH];
      end
      3'd2: begin
        w_res   = w_a - w_b;
        w_res_c = (w_a < w_b);
      end
      3'd3:    w_res = w_a & w_b;
      3'd4:    w_res = w_a | w_b;
      3'd5:    w_res = w_a ^ w_b;
      default: w_res = '0;
    endcase
  end

  // Instruction decode: stack write, next depth/top/carry, jump decision and depth violation
  always_comb begin
    w_viol     = 1'b0;
    w_wr_en    = 1'b0;
    w_wr_idx   = w_idx_new;
    w_wr_data  = w_pay;
    w_depth_nx = r_depth;
    w_carry_nx = r_carry;
    w_top_nx   = r_top;
    w_taken    = 1'b0;
    case (w_type)
      T_PUSH: begin
        w_viol     = w_full;
        w_wr_en    = 1'b1;
        w_depth_nx = r_depth + DW'(1);
        w_top_nx   = w_pay;
      end
      T_ALU: begin
        case (w_pay[2:0])
          3'd6: begin
            w_viol     = w_empty || w_full;
            w_wr_en    = 1'b1;
            w_wr_data  = r_top;
            w_depth_nx = r_depth + DW'(1);
          end
          3'd7: begin
            w_viol     = w_empty;
            w_depth_nx = r_depth - DW'(1);
            w_top_nx   = w_two ? w_a : '0;
          end
          default: begin
            w_viol     = !w_two;
            w_wr_en    = 1'b1;
            w_wr_idx   = w_idx_sec;
            w_wr_data  = w_res;
            w_depth_nx = r_depth - DW'(1);
            w_top_nx   = w_res;
            w_carry_nx = w_res_c;
          end
        endcase
      end
      T_JUMP: begin
        case (w_pay[WIDTH-1:WIDTH-2])
          2'd0: w_taken = 1'b1;
          2'd1: begin
            w_viol  = w_empty;
            w_taken = (r_top == '0);
          end
          2'd2: w_taken = r_carry;
          default: begin
            w_viol  = w_empty;
            w_taken = r_top[WIDTH-1];
          end
        endcase
      end
      default: ;
    endcase
  end

`ifdef STK_CPU_FAULT_EN
  logic r_fault;
`endif

  // Sequencer, architectural state and registered outputs
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_FETCH;
      r_pc        <= '0;
      r_ir        <= '0;
      r_depth     <= '0;
      r_carry     <= 1'b0;
      r_top       <= '0;
      r_fetch_req <= 1'b1;
      r_halted    <= 1'b0;
`ifdef STK_CPU_FAULT_EN
      r_fault     <= 1'b0;
`endif
      for (int unsigned i = 0; i < DEPTH; i++) r_stack[i] <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (i_fetch_ack) begin
            r_ir        <= i_instr;
            r_state     <= S_EXEC;
            r_fetch_req <= 1'b0;
          end
        end
        S_EXEC: begin
          if (w_type == 2'b11) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end
`ifdef STK_CPU_FAULT_EN
          else if (w_viol) begin
            r_state <= S_FAULT;
            r_fault <= 1'b1;
          end
`endif
          else begin
            r_state     <= S_FETCH;
            r_fetch_req <= 1'b1;
            if (w_viol) begin
              r_pc <= r_pc + WIDTH'(1);
            end else begin
              if (w_wr_en) r_stack[w_wr_idx] <= w_wr_data;
              r_depth <= w_depth_nx;
              r_carry <= w_carry_nx;
              r_top   <= w_top_nx;
              r_pc    <= w_taken ? w_target : r_pc + WIDTH'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_fetch_req  = r_fetch_req;
  assign o_instr_addr = r_pc;
  assign o_top        = r_top;
  assign o_depth      = r_depth;
  assign o_carry      = r_carry;
  assign o_halted     = r_halted;
`ifdef STK_CPU_FAULT_EN
  assign o_fault      = r_fault;
`else
  assign o_fault      = 1'b0;
`endif

endmodule

// File: tb/tb_stack_cpu_core.sv
// Self-checking bench for stack_cpu_core (WIDTH=16, DEPTH=4): queue-based reference model plus directed programs.
module tb_stack_cpu_core;
  localparam int unsigned W = 16;
  localparam int unsigned D = 4;
  localparam longint unsigned MOD = 64'd1 << W;

  logic          i_clock = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_fetch_ack = 1'b0;
  logic [W+1:0]  i_instr = '0;
  logic          o_fetch_req;
  logic [W-1:0]  o_instr_addr;
  logic [W-1:0]  o_top;
  logic [2:0]    o_depth;
  logic          o_carry;
  logic          o_halted;
  logic          o_fault;

  stack_cpu_core #(.WIDTH(W), .DEPTH(D)) dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .o_fetch_req(o_fetch_req), .o_instr_addr(o_instr_addr),
    .i_fetch_ack(i_fetch_ack), .i_instr(i_instr),
    .o_top(o_top), .o_depth(o_depth), .o_carry(o_carry),
    .o_halted(o_halted), .o_fault(o_fault)
  );

  always #5 i_clock = ~i_clock;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  logic [W+1:0] imem [256];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: architectural state straight from the instruction rules
  typedef enum int {M_FETCH, M_EXEC, M_HALT, M_FAULT} mst_t;
  mst_t         m_st;
  logic [W-1:0] m_pc;
  logic         m_carry;
  logic [W+1:0] m_ir;
  logic [W-1:0] m_stk [$];
  logic [W-1:0] m_a, m_b, m_p, m_t;
  logic [2:0]   m_op;
  logic [1:0]   m_cond;
  longint unsigned m_s;
  bit m_ok, m_tk;
  int m_d;

  always @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      m_st = M_FETCH; m_pc = '0; m_carry = 1'b0; m_ir = '0; m_stk.delete();
    end else if (m_st == M_FETCH) begin
      if (i_fetch_ack) begin m_ir = i_instr; m_st = M_EXEC; end
    end else if (m_st == M_EXEC) begin
      m_p = m_ir[W-1:0]; m_d = m_stk.size(); m_ok = 1'b1; m_tk = 1'b0;
      m_t = (m_d > 0) ? m_stk[m_d-1] : '0;
      m_op = m_p[2:0]; m_cond = m_p[W-1:W-2];
      case (m_ir[W+1:W])
        2'b00: begin m_ok = (m_d < D); if (m_ok) m_stk.push_back(m_p); end
        2'b01: begin
          if (m_op <= 3'd5) begin
            m_ok = (m_d >= 2);
            if (m_ok) begin
              m_b = m_stk.pop_back(); m_a = m_stk.pop_back();
              case (m_op)
                3'd0, 3'd1: begin
                  m_s = 64'(m_a) + 64'(m_b) + ((m_op == 3'd1) ? 64'(m_carry) : 64'd0);
                  m_carry = (m_s >= MOD);
                  m_stk.push_back(W'(m_s % MOD));
                end
                3'd2: begin
                  m_carry = (m_a < m_b);
                  m_stk.push_back(W'((64'(m_a) + MOD - 64'(m_b)) % MOD));
                end
                3'd3: m_stk.push_back(m_a & m_b);
                3'd4: m_stk.push_back(m_a | m_b);
                default: m_stk.push_back(m_a ^ m_b);
              endcase
            end
          end else if (m_op == 3'd6) begin
            m_ok = (m_d >= 1) && (m_d < D); if (m_ok) m_stk.push_back(m_t);
          end else begin
            m_ok = (m_d >= 1); if (m_ok) m_stk.delete(m_d-1);
          end
        end
        2'b10: begin
          m_ok = !((m_cond == 2'd1 || m_cond == 2'd3) && m_d == 0);
          m_tk = (m_cond == 2'd0) || (m_cond == 2'd1 && m_t == 0) ||
                 (m_cond == 2'd2 && m_carry) || (m_cond == 2'd3 && m_t[W-1]);
        end
        default: ;
      endcase
      if (m_ir[W+1:W] == 2'b11) m_st = M_HALT;
      else if (!m_ok) begin
`ifdef STK_CPU_FAULT_EN
        m_st = M_FAULT;
`else
        m_pc = W'(m_pc + 1); m_st = M_FETCH;
`endif
      end else begin
        m_pc = m_tk ? {2'b00, m_p[W-3:0]} : W'(m_pc + 1);
        m_st = M_FETCH;
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model
  always @(posedge i_clock) begin
    #2;
    if (chk_en) begin
      chk("fetch_req", 32'(o_fetch_req), 32'(m_st == M_FETCH));
      chk("instr_addr", 32'(o_instr_addr), 32'(m_pc));
      chk("top", 32'(o_top), (m_stk.size() > 0) ? 32'(m_stk[m_stk.size()-1]) : 32'd0);
      chk("depth", 32'(o_depth), 32'(m_stk.size()));
      chk("carry", 32'(o_carry), 32'(m_carry));
      chk("halted", 32'(o_halted), 32'(m_st == M_HALT));
      chk("fault", 32'(o_fault), 32'(m_st == M_FAULT));
    end
  end

  task automatic step(input bit ack);
    @(negedge i_clock);
    i_fetch_ack = ack;
    i_instr = imem[m_pc[7:0]];
    @(posedge i_clock);
    #2;
  endtask

  task automatic do_reset();
    @(negedge i_clock);
    i_reset = 1'b1; i_fetch_ack = 1'b0; chk_en = 1'b1;
    for (int i = 0; i < 256; i++) imem[i] = '0;
    @(negedge i_clock);
    @(negedge i_clock);
    i_reset = 1'b0;
  endtask

  task automatic ld(input int a, input logic [1:0] t, input logic [15:0] p);
    imem[a] = {t, p};
  endtask

  function automatic logic [15:0] jmp(input logic [1:0] c, input logic [13:0] tgt);
    return {c, tgt};
  endfunction

  task automatic run_prog(input string nm);
    int n = 0;
    while (m_st != M_HALT && m_st != M_FAULT && n < 200) begin step(1'b1); n++; end
    if (n >= 200) chk({nm, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic expect_out(input string nm, input logic [15:0] top, input int dep,
                            input bit c, input logic [15:0] pc);
    chk({nm, "_top"}, 32'(o_top), 32'(top));
    chk({nm, "_depth"}, 32'(o_depth), 32'(dep));
    chk({nm, "_carry"}, 32'(o_carry), 32'(c));
    chk({nm, "_pc"}, 32'(o_instr_addr), 32'(pc));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    // Reset values
    do_reset();
    chk("rst_fetch_req", 32'(o_fetch_req), 32'd1);
    expect_out("rst", 16'h0, 0, 1'b0, 16'h0);

    // ADD with carry out
    do_reset();
    ld(0, 2'b00, 16'hFFFF); ld(1, 2'b00, 16'h0001); ld(2, 2'b01, 16'd0); ld(3, 2'b11, 16'h0);
    run_prog("add");
    expect_out("add", 16'h0000, 1, 1'b1, 16'd3);
    chk("add_halted", 32'(o_halted), 32'd1);

    // SUB borrow, then ADC consuming the carry
    do_reset();
    ld(0, 2'b00, 16'd5); ld(1, 2'b00, 16'd7); ld(2, 2'b01, 16'd2); ld(3, 2'b11, 16'h0);
    run_prog("sub");
    expect_out("sub", 16'hFFFE, 1, 1'b1, 16'd3);
    do_reset();
    ld(0, 2'b00, 16'd5); ld(1, 2'b00, 16'd7); ld(2, 2'b01, 16'd2);
    ld(3, 2'b00, 16'd1); ld(4, 2'b01, 16'hFFF9); ld(5, 2'b11, 16'h0);
    run_prog("adc");
    expect_out("adc", 16'h0000, 1, 1'b1, 16'd5);

    // Fetch stall holds the address and all state
    do_reset();
    ld(0, 2'b00, 16'd9); ld(1, 2'b00, 16'd3); ld(2, 2'b11, 16'h0);
    step(1'b1); step(1'b1);
    repeat (5) begin
      step(1'b0);
      chk("stall_req", 32'(o_fetch_req), 32'd1);
      expect_out("stall", 16'd9, 1, 1'b0, 16'd1);
    end
    run_prog("stall");
    expect_out("stall_end", 16'd3, 2, 1'b0, 16'd2);

    // Conditional jumps: taken on zero, not taken on nonzero, taken on MSB
    do_reset();
    ld(0, 2'b00, 16'h0000); ld(1, 2'b10, jmp(2'd1, 14'h10));
    ld(16, 2'b00, 16'h0001); ld(17, 2'b10, jmp(2'd1, 14'h00));
    ld(18, 2'b00, 16'h8000); ld(19, 2'b10, jmp(2'd3, 14'h20)); ld(32, 2'b11, 16'h0);
    repeat (4) step(1'b1);
    chk("jmp_taken_pc", 32'(o_instr_addr), 32'h10);
    repeat (4) step(1'b1);
    chk("jmp_not_taken_pc", 32'(o_instr_addr), 32'h12);
    run_prog("jmp");
    expect_out("jmp", 16'h8000, 3, 1'b0, 16'h20);

    // Logic ops and DUP/DROP keep carry; carry-conditioned jump
    do_reset();
    ld(0, 2'b00, 16'hFFFF); ld(1, 2'b00, 16'h0001); ld(2, 2'b01, 16'd0); ld(3, 2'b01, 16'd7);
    ld(4, 2'b00, 16'h00F0); ld(5, 2'b01, 16'd6); ld(6, 2'b00, 16'h0F0F); ld(7, 2'b01, 16'd5);
    ld(8, 2'b01, 16'd4); ld(9, 2'b00, 16'h0FF0); ld(10, 2'b01, 16'd3);
    ld(11, 2'b10, jmp(2'd2, 14'h30)); ld(48, 2'b11, 16'h0);
    run_prog("logic");
    expect_out("logic", 16'h0FF0, 1, 1'b1, 16'h30);

    // HALT ignores further acks
    repeat (10) step(1'b1);
    chk("halt_halted", 32'(o_halted), 32'd1);
    chk("halt_req", 32'(o_fetch_req), 32'd0);
    expect_out("halt", 16'h0FF0, 1, 1'b1, 16'h30);

    // Mid-cycle reset clears outputs immediately
    #1;
    i_reset = 1'b1;
    #1;
    chk("mrst_req", 32'(o_fetch_req), 32'd1);
    chk("mrst_halted", 32'(o_halted), 32'd0);
    chk("mrst_fault", 32'(o_fault), 32'd0);
    expect_out("mrst", 16'h0, 0, 1'b0, 16'h0);

    // Overflow on the fifth PUSH
    do_reset();
    for (int i = 0; i < 5; i++) ld(i, 2'b00, 16'(i + 1));
    ld(5, 2'b11, 16'h0);
    run_prog("ovf");
`ifdef STK_CPU_FAULT_EN
    expect_out("ovf", 16'd4, 4, 1'b0, 16'd4);
    chk("ovf_fault", 32'(o_fault), 32'd1);
`else
    expect_out("ovf", 16'd4, 4, 1'b0, 16'd5);
    chk("ovf_fault", 32'(o_fault), 32'd0);
`endif

    // Underflow: binary op on one entry, DROP and conditional JUMP on empty
    do_reset();
    ld(0, 2'b00, 16'd2); ld(1, 2'b01, 16'd0); ld(2, 2'b01, 16'd7); ld(3, 2'b01, 16'd7);
    ld(4, 2'b10, jmp(2'd1, 14'h3F)); ld(5, 2'b11, 16'h0);
    run_prog("udf");
`ifdef STK_CPU_FAULT_EN
    expect_out("udf", 16'd2, 1, 1'b0, 16'd1);
    chk("udf_fault", 32'(o_fault), 32'd1);
`else
    expect_out("udf", 16'd0, 0, 1'b0, 16'd5);
    chk("udf_halted", 32'(o_halted), 32'd1);
`endif

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
